jstk2_spi_responder: RTL and testbench

- SPI mode-0 peripheral: the responder end of the joystick SPI link.
- Emulates a PmodJSTK2: receives a command and parameters on MOSI and returns a 5-byte position/button packet on MISO.
- Used as a loopback target in simulation and on the board, for bring-up of the SPI master and PS driver without the physical Pmod.
- Oversamples SCLK/SS/MOSI in the single system clock domain.

---
 rtl/jstk2_spi_responder.sv | 204 ++++++++++++++++++++
 tb/tb_jstk2_spi_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jstk2_spi_responder.sv
// PmodJSTK2 emulator: SPI mode-0 responder returning a 5-byte position/button packet.
// Optional frame-error reporting is enabled by defining JSTK2_FRAME_ERR_EN.
module jstk2_spi_responder #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FRAME_BYTES = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sclk,
    input  logic       i_ss_n,
    input  logic       i_mosi,
    output logic       o_miso,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic [1:0] i_btn,
    output logic [7:0] o_cmd,
    output logic       o_cmd_valid,
`ifdef JSTK2_FRAME_ERR_EN
    output logic       o_frame_err,
    output logic [7:0] o_err_count,
`endif
    output logic [7:0] o_led_r,
    output logic [7:0] o_led_g,
    output logic [7:0] o_led_b
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_t;

    state_t                  r_state, w_state_next;
    logic [SYNC_STAGES-1:0]  r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic                    r_sclk_prev, r_ss_prev;
    logic                    r_restart;
    logic [39:0]             r_frame;
    logic [DATA_WIDTH-1:0]   r_tx, r_rx;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [2:0]              r_byte_idx;
    logic [7:0]              r_cmd_byte, r_p1, r_p2, r_p3;
    logic                    r_miso;

    logic                    w_sclk, w_ss, w_mosi;
    logic                    w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
    logic [39:0]             w_load_frame;
    logic [DATA_WIDTH-1:0]   w_rx_byte, w_tx0;
    logic [2:0]              w_idx_next;

    function automatic logic [DATA_WIDTH-1:0] tx_byte(input logic [39:0] frame,
                                                      input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = frame[7:0];
            3'd1:    b = frame[15:8];
            3'd2:    b = frame[23:16];
            3'd3:    b = frame[31:24];
            3'd4:    b = frame[39:32];
            default: b = 8'h00;
        endcase
        if (32'(idx) >= FRAME_BYTES) b = 8'h00;
        return DATA_WIDTH'(b);
    endfunction

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_ss_rise   = w_ss & ~r_ss_prev;
    assign w_ss_fall   = ~w_ss & r_ss_prev;

    assign w_load_frame = {6'b0, i_btn, 6'b0, i_y[9:8], i_y[7:0], 6'b0, i_x[9:8], i_x[7:0]};
    assign w_tx0        = tx_byte(w_load_frame, 3'd0);
    assign w_rx_byte    = {r_rx[DATA_WIDTH-2:0], w_mosi};
    assign w_idx_next   = (r_byte_idx == 3'd7) ? 3'd7 : r_byte_idx + 3'd1;

    assign o_miso = r_miso & ~w_ss;

    // SS resets high so that a deasserted select never looks like a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= w_sclk;
            r_ss_prev   <= w_ss;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_restart <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_restart <= (r_state == StDone) && w_ss_fall;
        end
    end

    // r_restart keeps an SS fall seen during DONE so IDLE can still start the frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_ss_fall || r_restart) w_state_next = StLoad;
            StLoad:  w_state_next = StShift;
            StShift: w_state_next = StShift;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
        if (w_ss_rise) w_state_next = StDone;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame     <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_bit_cnt   <= '0;
            r_byte_idx  <= '0;
            r_cmd_byte  <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_p3        <= '0;
            r_miso      <= 1'b0;
            o_cmd       <= '0;
            o_cmd_valid <= 1'b0;
            o_led_r     <= '0;
            o_led_g     <= '0;
            o_led_b     <= '0;
        end else begin
            o_cmd_valid <= 1'b0;
            case (r_state)
                StLoad: begin
                    r_frame    <= w_load_frame;
                    r_tx       <= w_tx0;
                    r_miso     <= w_tx0[DATA_WIDTH-1];
                    r_bit_cnt  <= '0;
                    r_byte_idx <= '0;
                end
                StShift: begin
                    if (!w_ss && w_sclk_rise) begin
                        r_rx <= w_rx_byte;
                        if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                            r_bit_cnt  <= '0;
                            r_byte_idx <= w_idx_next;
                            r_tx       <= tx_byte(r_frame, w_idx_next);
                            case (r_byte_idx)
                                3'd0:    r_cmd_byte <= 8'(w_rx_byte);
                                3'd1:    r_p1       <= 8'(w_rx_byte);
                                3'd2:    r_p2       <= 8'(w_rx_byte);
                                3'd3:    r_p3       <= 8'(w_rx_byte);
                                default: ;
                            endcase
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (!w_ss && w_sclk_fall) begin
                        // Bit count already points at the next bit; 0 selects the new byte's MSB.
                        r_miso <= r_tx[BIT_W'(DATA_WIDTH - 1) - r_bit_cnt];
                    end
                end
                StDone: begin
                    if (r_byte_idx != 3'd0) begin
                        o_cmd       <= r_cmd_byte;
                        o_cmd_valid <= 1'b1;
                        if (r_cmd_byte == 8'h84 && r_byte_idx >= 3'd4) begin
                            o_led_r <= r_p1;
                            o_led_g <= r_p2;
                            o_led_b <= r_p3;
                        end
                    end
                    r_bit_cnt  <= '0;
                    r_byte_idx <= '0;
                    r_miso     <= 1'b0;
                end
                default: r_miso <= 1'b0;
            endcase
        end
    end

`ifdef JSTK2_FRAME_ERR_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_frame_err <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_frame_err <= 1'b0;
            if (r_state == StDone && r_bit_cnt != '0) begin
                o_frame_err <= 1'b1;
                if (o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
            end
        end
    end
`else
    // Partial bytes are dropped silently when SS rises mid-byte.
`endif

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Directed bench for jstk2_spi_responder: vector table of whole frames plus corner sequences.
module tb_jstk2_spi_responder;

    logic       clk = 1'b0;
    logic       reset, sclk, ss_n, mosi, miso;
    logic [9:0] x, y;
    logic [1:0] btn;
    logic [7:0] cmd, led_r, led_g, led_b;
    logic       cmd_valid;
`ifdef JSTK2_FRAME_ERR_EN
    logic       frame_err;
    logic [7:0] err_count;
    int         n_err_pulse = 0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int n_valid = 0;

    always #5 clk = ~clk;

    jstk2_spi_responder #(
        .DATA_WIDTH (8),
        .FRAME_BYTES(5),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_sclk     (sclk),
        .i_ss_n     (ss_n),
        .i_mosi     (mosi),
        .o_miso     (miso),
        .i_x        (x),
        .i_y        (y),
        .i_btn      (btn),
        .o_cmd      (cmd),
        .o_cmd_valid(cmd_valid),
`ifdef JSTK2_FRAME_ERR_EN
        .o_frame_err(frame_err),
        .o_err_count(err_count),
`endif
        .o_led_r    (led_r),
        .o_led_g    (led_g),
        .o_led_b    (led_b)
    );

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) n_valid++;
`ifdef JSTK2_FRAME_ERR_EN
        if (frame_err === 1'b1) n_err_pulse++;
`endif
    end

    typedef struct packed {
        logic [55:0] mosi;
        logic [2:0]  nbytes;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [1:0]  btn;
        logic [55:0] miso;
        logic [7:0]  cmd;
        logic [7:0]  led_r;
        logic [7:0]  led_g;
        logic [7:0]  led_b;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            half();
            sclk = 1'b1;
            rx[i] = miso;
            half();
            sclk = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rx;
        int         v0;
        vec_t       v;

        // Byte 0 of mosi/miso sits in the least significant byte.
        vecs[0] = '{56'h00_00_00_00_00_00_C0, 3'd5, 10'h2A5, 10'h10F, 2'b10,
                    56'h00_00_02_01_0F_02_A5, 8'hC0, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{56'h00_00_00_33_22_11_84, 3'd5, 10'h2A5, 10'h10F, 2'b10,
                    56'h00_00_02_01_0F_02_A5, 8'h84, 8'h11, 8'h22, 8'h33};
        vecs[2] = '{56'h00_00_00_00_00_55_84, 3'd2, 10'h2A5, 10'h10F, 2'b10,
                    56'h00_00_00_00_00_02_A5, 8'h84, 8'h11, 8'h22, 8'h33};
        vecs[3] = '{56'h00_00_00_00_99_77_12, 3'd3, 10'h155, 10'h2EA, 2'b01,
                    56'h00_00_00_00_EA_01_55, 8'h12, 8'h11, 8'h22, 8'h33};
        vecs[4] = '{56'h00_00_00_CC_BB_AA_84, 3'd4, 10'h000, 10'h3FF, 2'b11,
                    56'h00_00_00_03_FF_00_00, 8'h84, 8'hAA, 8'hBB, 8'hCC};
        vecs[5] = '{56'h66_55_44_33_22_11_C0, 3'd7, 10'h2A5, 10'h10F, 2'b10,
                    56'h00_00_02_01_0F_02_A5, 8'hC0, 8'hAA, 8'hBB, 8'hCC};

        reset = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        x = '0; y = '0; btn = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_miso", 32'(miso), 32'h0);
        check("reset_cmd", 32'(cmd), 32'h0);
        check("reset_valid", 32'(n_valid), 32'h0);
        check("reset_leds", {8'h0, led_r, led_g, led_b}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            v  = vecs[i];
            x  = v.x; y = v.y; btn = v.btn;
            v0 = n_valid;
            ss_n = 1'b0;
            half();
            for (int b = 0; b < int'(v.nbytes); b++) begin
                spi_bits(v.mosi[8*b +: 8], 8, rx);
                check($sformatf("v%0d_miso_byte%0d", i, b), 32'(rx), 32'(v.miso[8*b +: 8]));
            end
            half();
            ss_n = 1'b1;
            repeat (10) @(negedge clk);
            check($sformatf("v%0d_valid_pulses", i), 32'(n_valid - v0), 32'd1);
            check($sformatf("v%0d_cmd", i), 32'(cmd), 32'(v.cmd));
            check($sformatf("v%0d_leds", i), {8'h0, led_r, led_g, led_b},
                  {8'h0, v.led_r, v.led_g, v.led_b});
            check($sformatf("v%0d_miso_idle", i), 32'(miso), 32'h0);
        end

        // Snapshot coherence: X changes after byte 0 but byte 1 keeps the old high bits.
        x = 10'h3FF; y = 10'h000; btn = 2'b00;
        v0 = n_valid;
        ss_n = 1'b0;
        half();
        spi_bits(8'h5A, 8, rx);
        check("snap_byte0", 32'(rx), 32'hFF);
        x = 10'h000;
        spi_bits(8'h00, 8, rx);
        check("snap_byte1", 32'(rx), 32'h03);
        half();
        ss_n = 1'b1;
        repeat (10) @(negedge clk);
        check("snap_valid", 32'(n_valid - v0), 32'd1);
        check("snap_cmd", 32'(cmd), 32'h5A);

        // Abort after 3 SCLKs of byte 0.
        v0 = n_valid;
        ss_n = 1'b0;
        half();
        spi_bits(8'h84, 3, rx);
        half();
        ss_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_valid", 32'(n_valid - v0), 32'd0);
        check("abort_miso", 32'(miso), 32'h0);
        check("abort_cmd", 32'(cmd), 32'h5A);
`ifdef JSTK2_FRAME_ERR_EN
        check("abort_err_pulse", 32'(n_err_pulse), 32'd1);
        check("abort_err_count", 32'(err_count), 32'd1);
`endif

        // Reset mid-byte 2 drops the frame and restores reset values.
        x = 10'h2A5; y = 10'h10F; btn = 2'b10;
        v0 = n_valid;
        ss_n = 1'b0;
        half();
        spi_bits(8'h84, 8, rx);
        spi_bits(8'h11, 8, rx);
        spi_bits(8'h22, 3, rx);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_leds", {8'h0, led_r, led_g, led_b}, 32'h0);
        check("rst_miso", 32'(miso), 32'h0);
        reset = 1'b0;
        half();
        ss_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_valid", 32'(n_valid - v0), 32'd0);
        check("rst_cmd_after", 32'(cmd), 32'h0);
`ifdef JSTK2_FRAME_ERR_EN
        check("rst_err_count", 32'(err_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
